// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported, fixed-latency memory between
// the instruction-fetch port and the data port. Data has priority, and a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants taken while a fetch was waiting. One transaction is in flight at a
// time. Every output comes straight from a flop.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q,     state_d;
  logic [3:0]        lat_cnt_q,   lat_cnt_d;
  logic [3:0]        starve_q,    starve_d;
  logic              grant_if_q,  grant_if_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              d_ready_q,   d_ready_d;
  logic              pick_if;

  // Next-state logic: grant selection, latency countdown and response capture.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    grant_if_d  = grant_if_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    pick_if     = if_req && (!d_req || (starve_q == STARVE_LIM));

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant_if_d  = pick_if;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_if ? 1'b0 : d_we;
          mem_addr_d  = pick_if ? if_addr : d_addr;
          mem_wdata_d = pick_if ? mem_wdata_q : d_wdata;
          if (pick_if) begin
            starve_d = '0;
          end else if (if_req) begin
            starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        // The count reaches zero on this edge: mem_rdata is valid right now.
        if (lat_cnt_q == 4'd1) begin
          if (grant_if_q) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_ready_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset aborts any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      grant_if_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      grant_if_q  <= grant_if_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance with MEM_LAT=2 and one
// with MEM_LAT=1, both on a shared behavioural memory.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Instance 1 (MEM_LAT=2)
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Instance 2 (MEM_LAT=1)
  logic          if_req2 = 1'b0;
  logic [AW-1:0] if_addr2 = '0;
  logic [DW-1:0] if_rdata2;
  logic          if_ready2;
  logic          d_req2 = 1'b0;
  logic          d_we2 = 1'b0;
  logic [AW-1:0] d_addr2 = '0;
  logic [DW-1:0] d_wdata2 = '0;
  logic [DW-1:0] d_rdata2;
  logic          d_ready2;
  logic          mem_en2, mem_we2;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_wdata2, mem_rdata2;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut2 (
    .clk(clk), .reset(reset),
    .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_ready(d_ready2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  // Behavioural memory: word array, read data valid only in its latency slot.
  logic [DW-1:0] mem [256];
  logic [1:0]    p1_v = 2'b00;
  logic [DW-1:0] p1_d0 = '0, p1_d1 = '0;
  logic          p2_v = 1'b0;
  logic [DW-1:0] p2_d0 = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_en2 && mem_we2) mem[mem_addr2[9:2]] <= mem_wdata2;
    p1_v  <= {p1_v[0], mem_en && !mem_we};
    p1_d0 <= mem[mem_addr[9:2]];
    p1_d1 <= p1_d0;
    p2_v  <= mem_en2 && !mem_we2;
    p2_d0 <= mem[mem_addr2[9:2]];
  end

  assign mem_rdata  = p1_v[1] ? p1_d1 : 32'hDEADBEEF;
  assign mem_rdata2 = p2_v ? p2_d0 : 32'hDEADBEEF;

  task automatic test_reset();
    @(negedge clk);
    chk_cnt++;
    if ({if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_outputs: if_rdata=%h d_rdata=%h mem_en=%b mem_addr=%h, need all 0",
               if_rdata, d_rdata, mem_en, mem_addr);
    else pass_cnt++;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
      $display("FAIL idle_after_reset: if_ready=%b d_ready=%b mem_en=%b, need all 0",
               if_ready, d_ready, mem_en);
    else pass_cnt++;
  endtask

  task automatic test_fetch();
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0)
          $display("FAIL fetch_issue: mem_en=%b mem_addr=%h mem_we=%b, need 1/00000040/0",
                   mem_en, mem_addr, mem_we);
        else pass_cnt++;
      end else if (c == 2 || c == 3) begin
        chk_cnt++;
        if ({mem_en, if_ready, d_ready} !== 3'b000)
          $display("FAIL fetch_wait_c%0d: mem_en/if_ready/d_ready=%b, need 000", c,
                   {mem_en, if_ready, d_ready});
        else pass_cnt++;
      end else if (c == 4) begin
        chk_cnt++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C010004 || d_ready !== 1'b0)
          $display("FAIL fetch_ready: if_ready=%b if_rdata=%h d_ready=%b, need 1/8c010004/0",
                   if_ready, if_rdata, d_ready);
        else pass_cnt++;
        if_req = 1'b0;
      end else begin
        chk_cnt++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h8C010004)
          $display("FAIL fetch_pulse_hold: if_ready=%b if_rdata=%h, need 0/8c010004",
                   if_ready, if_rdata);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_write_read();
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1234)
          $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h, need 1/1/00000100/00001234",
                   mem_en, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
      end else if (c == 4) begin
        chk_cnt++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h0)
          $display("FAIL write_ready: d_ready=%b d_rdata=%h, need 1/00000000", d_ready, d_rdata);
        else pass_cnt++;
        d_req = 1'b0; d_we = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100)
          $display("FAIL read_issue: en=%b we=%b addr=%h, need 1/0/00000100",
                   mem_en, mem_we, mem_addr);
        else pass_cnt++;
      end else if (c == 4) begin
        chk_cnt++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1234)
          $display("FAIL read_ready: d_ready=%b d_rdata=%h, need 1/00001234", d_ready, d_rdata);
        else pass_cnt++;
        d_req = 1'b0;
      end else if (c >= 5) begin
        chk_cnt++;
        if (d_ready !== 1'b0 || d_rdata !== 32'h1234 || mem_en !== 1'b0)
          $display("FAIL read_hold_c%0d: d_ready=%b d_rdata=%h mem_en=%b, need 0/00001234/0",
                   c, d_ready, d_rdata, mem_en);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_simultaneous();
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100)
          $display("FAIL simul_first: mem_en=%b mem_addr=%h, need 1/00000100", mem_en, mem_addr);
        else pass_cnt++;
      end else if (c == 4) begin
        chk_cnt++;
        if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== 32'h1234)
          $display("FAIL simul_dready: d_ready=%b if_ready=%b d_rdata=%h, need 1/0/00001234",
                   d_ready, if_ready, d_rdata);
        else pass_cnt++;
        d_req = 1'b0;
      end else if (c == 5) begin
        chk_cnt++;
        if (mem_en !== 1'b0)
          $display("FAIL simul_gap: mem_en=%b, need 0", mem_en);
        else pass_cnt++;
      end else if (c == 6) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0)
          $display("FAIL simul_second: en=%b addr=%h we=%b, need 1/00000040/0",
                   mem_en, mem_addr, mem_we);
        else pass_cnt++;
      end else if (c == 8) begin
        chk_cnt++;
        if (if_ready !== 1'b0)
          $display("FAIL simul_early_if: if_ready=%b, need 0", if_ready);
        else pass_cnt++;
      end else if (c == 9) begin
        chk_cnt++;
        if (if_ready !== 1'b1 || d_ready !== 1'b0 || if_rdata !== 32'h8C010004)
          $display("FAIL simul_ifready: if_ready=%b d_ready=%b if_rdata=%h, need 1/0/8c010004",
                   if_ready, d_ready, if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_starvation();
    logic [10:0] seq;
    int ng;
    int bad_t;
    seq = '0; ng = 0; bad_t = 0;
    repeat (2) @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 1; c <= 54; c++) begin
      @(negedge clk);
      if (mem_en !== ((c % 5) == 1)) bad_t++;
      if (mem_en === 1'b1) begin
        if (ng < 11) seq[ng] = (mem_addr == 32'h40);
        ng++;
      end
      if (c == 54) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    chk_cnt++;
    if (ng !== 11)
      $display("FAIL starve_count: grants=%0d, need 11", ng);
    else pass_cnt++;
    chk_cnt++;
    if (seq !== 11'b01000010000)
      $display("FAIL starve_order: fetch-grant mask=%b, need 01000010000", seq);
    else pass_cnt++;
    chk_cnt++;
    if (bad_t !== 0)
      $display("FAIL starve_spacing: %0d cycles with misplaced mem_en, need 0", bad_t);
    else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    int seen;
    seen = 0;
    repeat (3) @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk_cnt++;
    if (mem_en !== 1'b1)
      $display("FAIL rstw_issue: mem_en=%b, need 1", mem_en);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    #1;
    chk_cnt++;
    if ({if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata} !== '0 ||
        {if_rdata2, d_rdata2, mem_en2, mem_addr2} !== '0)
      $display("FAIL rstw_outputs: if_rdata=%h d_rdata=%h mem_en=%b mem_addr=%h, need all 0",
               if_rdata, d_rdata, mem_en, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_en) seen++;
    end
    chk_cnt++;
    if (seen !== 0)
      $display("FAIL rstw_no_pulse: %0d cycles with activity, need 0", seen);
    else pass_cnt++;
    if_req = 1'b1; if_addr = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h40)
          $display("FAIL rstw_new_issue: mem_en=%b mem_addr=%h, need 1/00000040", mem_en, mem_addr);
        else pass_cnt++;
      end else if (c == 4) begin
        chk_cnt++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C010004)
          $display("FAIL rstw_new_ready: if_ready=%b if_rdata=%h, need 1/8c010004",
                   if_ready, if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_lat1();
    repeat (2) @(negedge clk);
    d_req2 = 1'b1; d_we2 = 1'b0; d_addr2 = 32'h100;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en2 !== 1'b1 || mem_addr2 !== 32'h100)
          $display("FAIL lat1_issue: mem_en=%b mem_addr=%h, need 1/00000100", mem_en2, mem_addr2);
        else pass_cnt++;
      end else if (c == 2) begin
        chk_cnt++;
        if (d_ready2 !== 1'b0)
          $display("FAIL lat1_early: d_ready=%b, need 0", d_ready2);
        else pass_cnt++;
      end else begin
        chk_cnt++;
        if (d_ready2 !== 1'b1 || d_rdata2 !== 32'h1234)
          $display("FAIL lat1_ready: d_ready=%b d_rdata=%h, need 1/00001234", d_ready2, d_rdata2);
        else pass_cnt++;
        d_req2 = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    if_req2 = 1'b1; if_addr2 = 32'h40;
    d_req2 = 1'b1; d_addr2 = 32'h100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk_cnt++;
        if (mem_en2 !== 1'b1 || mem_addr2 !== 32'h100)
          $display("FAIL lat1_simul_first: en=%b addr=%h, need 1/00000100", mem_en2, mem_addr2);
        else pass_cnt++;
      end else if (c == 3) begin
        chk_cnt++;
        if (d_ready2 !== 1'b1 || if_ready2 !== 1'b0)
          $display("FAIL lat1_simul_d: d_ready=%b if_ready=%b, need 1/0", d_ready2, if_ready2);
        else pass_cnt++;
        d_req2 = 1'b0;
      end else if (c == 5) begin
        chk_cnt++;
        if (mem_en2 !== 1'b1 || mem_addr2 !== 32'h40)
          $display("FAIL lat1_simul_second: en=%b addr=%h, need 1/00000040", mem_en2, mem_addr2);
        else pass_cnt++;
      end else if (c == 7) begin
        chk_cnt++;
        if (if_ready2 !== 1'b1 || d_ready2 !== 1'b0 || if_rdata2 !== 32'h8C010004)
          $display("FAIL lat1_simul_if: if_ready=%b d_ready=%b if_rdata=%h, need 1/0/8c010004",
                   if_ready2, d_ready2, if_rdata2);
        else pass_cnt++;
        if_req2 = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'h8C010004;
    test_reset();
    test_fetch();
    test_write_read();
    test_simultaneous();
    test_starvation();
    test_reset_wait();
    test_lat1();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
